// File: rtl/mod997_pkg.sv
// Shared definitions for the mod-997 residue path.
//
// Contents:
//   MODULUS_997 - reduction modulus
//   RES_W       - residue width in bits
//   state_t     - accumulator state encoding (ACC, DONE)
//   residue_t   - one reduced residue
package mod997_pkg;

    localparam int MODULUS_997 = 997;
    localparam int RES_W       = 10;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    typedef logic [RES_W-1:0] residue_t;

endpackage : mod997_pkg

// File: rtl/mod997_modadd.sv
// Combinational modular adder: sum = (a + b) mod MODULUS.
// Only one conditional subtraction is applied, so the result is fully
// reduced only when both operands are already below MODULUS. With b = 0 it
// serves as a single-step pre-reduction of a possibly out-of-range value.
//
// Ports:
//   a   in  RES_W  first operand
//   b   in  RES_W  second operand
//   sum out RES_W  a + b, less MODULUS when a + b >= MODULUS
module mod997_modadd
    import mod997_pkg::*;
#(
    parameter int MODULUS = MODULUS_997,
    parameter int RES_W   = 10
) (
    input  logic [RES_W-1:0] a,
    input  logic [RES_W-1:0] b,
    output logic [RES_W-1:0] sum
);

    // One extra bit holds the carry and also lets MODULUS == 2**RES_W fit.
    localparam logic [RES_W:0] MOD_EXT = (RES_W+1)'(MODULUS);

    logic [RES_W:0] raw_sum;
    logic [RES_W:0] red_sum;

    always_comb begin
        raw_sum = {1'b0, a} + {1'b0, b};
        red_sum = raw_sum;
        if (raw_sum >= MOD_EXT) begin
            red_sum = raw_sum - MOD_EXT;
        end
    end

    // After at most one subtraction the value is below MODULUS <= 2**RES_W,
    // so the top bit is always zero here.
    assign sum = red_sum[RES_W-1:0];

endmodule : mod997_modadd

// File: rtl/mod997_residue_accum.sv
// Sequential modulo-MODULUS accumulator for bursts of residue beats.
// Beats are summed modulo MODULUS; the final beat (in_last) latches the
// reduced sum and the saturating beat count, and the block then holds the
// result in DONE until the consumer takes it. No beat is accepted in DONE.
//
// Optional feature macro: MOD997_ACC_RANGE_CHECK_EN
//   defined   - accepted in_res >= MODULUS is pre-reduced by one subtraction
//               and raises the sticky err flag (cleared only by rst)
//   undefined - no pre-reduction, err tied to 0
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      residue beat valid
//   in_ready   out  1      block accepts a beat (high in ACC)
//   in_res     in   RES_W  residue beat
//   in_last    in   1      final beat of the operand
//   out_valid  out  1      result valid (high in DONE)
//   out_ready  in   1      consumer accepts the result
//   out_res    out  RES_W  reduced sum, always < MODULUS
//   out_beats  out  CNT_W  beats in the burst, saturating
//   err        out  1      sticky range error
module mod997_residue_accum
    import mod997_pkg::*;
#(
    parameter int MODULUS = MODULUS_997,
    parameter int RES_W   = 10,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_res,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_res,
    output logic [CNT_W-1:0] out_beats,
    output logic             err
);

    state_t           state;
    logic [RES_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [RES_W-1:0] add_op;
    logic [RES_W-1:0] acc_sum;
    logic             accept;

    // Handshake outputs decode the state register only, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Beat counter holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

`ifdef MOD997_ACC_RANGE_CHECK_EN
    localparam logic [RES_W:0] MOD_EXT = (RES_W+1)'(MODULUS);

    logic err_q;
    logic in_oor;

    assign in_oor = ({1'b0, in_res} >= MOD_EXT);

    // Adding zero with one conditional subtraction folds an out-of-range
    // beat back into [0, MODULUS) before it reaches the accumulator.
    mod997_modadd #(
        .MODULUS (MODULUS),
        .RES_W   (RES_W)
    ) u_prereduce (
        .a   (in_res),
        .b   ({RES_W{1'b0}}),
        .sum (add_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && in_oor) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign add_op = in_res;
    assign err    = 1'b0;
`endif

    mod997_modadd #(
        .MODULUS (MODULUS),
        .RES_W   (RES_W)
    ) u_accum_add (
        .a   (acc),
        .b   (add_op),
        .sum (acc_sum)
    );

    // Reset clears the partial sum and any pending result as well as the
    // state, so a burst interrupted by rst leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            out_res   <= '0;
            out_beats <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        if (in_last) begin
                            out_res   <= acc_sum;
                            out_beats <= cnt_inc;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= DONE;
                        end else begin
                            acc <= acc_sum;
                            cnt <= cnt_inc;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule : mod997_residue_accum
